pal_pattern_gen: RTL

//  Parametrised composite-video (PAL luma) timing and test-pattern generator, sitting between the

---
 rtl/pal_pattern_gen.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pal_pattern_gen.sv
`timescale 1ns/1ps
// PAL luma timing and test-pattern generator: line/field counters, sync/blank/active levels,
// four patterns and registered timing strobes. Optional interlace via PALGEN_INTERLACE_EN.
module pal_pattern_gen #(
  parameter int DW           = 8,
  parameter int LINE_LEN     = 914,
  parameter int HSYNC_LEN    = 67,
  parameter int BPORCH_LEN   = 81,
  parameter int ACTIVE_LEN   = 743,
  parameter int LINES        = 312,
  parameter int VSYNC_LINES  = 3,
  parameter int VBLANK_LINES = 22,
  parameter int SYNC_LVL     = 0,
  parameter int BLANK_LVL    = 77,
  parameter int WHITE_LVL    = 255,
  parameter int CHK_SHIFT    = 5
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    pattern_sel,
  output logic [DW-1:0] sample_out,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          active_o,
  output logic          frame_start,
  output logic          field_o
);

  localparam int HW    = $clog2(LINE_LEN);
  localparam int VW    = $clog2(LINES + 2);
  localparam int XW    = $clog2(ACTIVE_LEN);
  localparam int LW    = DW + 1;
  localparam int BAR_W = (ACTIVE_LEN + 7) / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] HC_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HSYNC_END  = HW'(HSYNC_LEN);
  localparam logic [HW-1:0] HALF_LINE  = HW'(LINE_LEN / 2);
  localparam logic [HW-1:0] BROAD1_END = HW'(LINE_LEN / 2 - HSYNC_LEN);
  localparam logic [HW-1:0] BROAD2_END = HW'(LINE_LEN - HSYNC_LEN);
  localparam logic [HW-1:0] ACT_START  = HW'(HSYNC_LEN + BPORCH_LEN);
  localparam logic [HW-1:0] ACT_PRE    = HW'(HSYNC_LEN + BPORCH_LEN - 1);
  localparam logic [HW-1:0] ACT_END    = HW'(HSYNC_LEN + BPORCH_LEN + ACTIVE_LEN);

  localparam logic [VW-1:0] VC_LAST0   = VW'(LINES - 1);
  localparam logic [VW-1:0] VSYNC_END  = VW'(VSYNC_LINES);
  localparam logic [VW-1:0] VBLANK_END = VW'(VBLANK_LINES);
  localparam logic [VW-1:0] Y_MASK     = VW'(2 ** CHK_SHIFT);
  localparam logic [XW-1:0] X_MASK     = XW'(2 ** CHK_SHIFT);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

  localparam logic [LW-1:0] BLANK_W = LW'(BLANK_LVL);
  localparam logic [LW-1:0] WHITE_W = LW'(WHITE_LVL);
  localparam logic [LW-1:0] STEP_W  = LW'((WHITE_LVL - BLANK_LVL) / 7);

  localparam logic [DW-1:0] SYNC_C  = DW'(SYNC_LVL);
  localparam logic [DW-1:0] BLANK_C = DW'(BLANK_LVL);
  localparam logic [DW-1:0] WHITE_C = DW'(WHITE_LVL);
  localparam logic [DW-1:0] FLAT_C  = DW'((BLANK_LVL + WHITE_LVL) / 2);

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [1:0]    pat_q, pat_d;
  logic [BW-1:0] bsub_q, bsub_d;
  logic [2:0]    bidx_q, bidx_d;
  logic          field_d;
  logic          last_vc;
  logic          at_origin;

  logic          broad_line, sync_tim, in_act_h, active_tim, chk_bit;
  logic [XW-1:0] x;
  logic [VW-1:0] y;
  logic [LW-1:0] ramp_sum, bar_lvl;
  logic [DW-1:0] sample_d;
  logic          hsync_d, active_d, fs_d;

`ifdef PALGEN_INTERLACE_EN
  localparam logic [VW-1:0] VC_LAST1 = VW'(LINES);
  logic field_q;

  // Field 1 carries the extra half-frame line so a frame is 2*LINES+1 lines.
  assign last_vc = (vc_q == (field_q ? VC_LAST1 : VC_LAST0));
  assign field_d = (hc_q == HC_LAST && last_vc) ? ~field_q : field_q;
  assign fs_d    = at_origin && !field_q;
`else
  assign last_vc = (vc_q == VC_LAST0);
  assign field_d = 1'b0;
  assign fs_d    = at_origin;
  assign field_o = 1'b0;
`endif

  assign at_origin = (hc_q == '0) && (vc_q == '0);

  always_comb begin
    hc_d = hc_q + HW'(1);
    vc_d = vc_q;
    if (hc_q == HC_LAST) begin
      hc_d = '0;
      vc_d = last_vc ? '0 : vc_q + VW'(1);
    end
    pat_d = at_origin ? pattern_sel : pat_q;
  end

  // Bar index follows x without a divider: a sub-counter wraps every BAR_W samples.
  always_comb begin
    bsub_d = bsub_q;
    bidx_d = bidx_q;
    if (hc_q == ACT_PRE) begin
      bsub_d = '0;
      bidx_d = '0;
    end else if (in_act_h) begin
      if (bsub_q == BAR_LAST) begin
        bsub_d = '0;
        bidx_d = (bidx_q == 3'd7) ? 3'd7 : bidx_q + 3'd1;
      end else begin
        bsub_d = bsub_q + BW'(1);
      end
    end
  end

  always_comb begin
    broad_line = (vc_q < VSYNC_END);
    sync_tim   = broad_line ? ((hc_q < BROAD1_END) || (hc_q >= HALF_LINE && hc_q < BROAD2_END))
                            : (hc_q < HSYNC_END);
    in_act_h   = (hc_q >= ACT_START) && (hc_q < ACT_END);
    active_tim = in_act_h && (vc_q >= VBLANK_END);
    x          = XW'(hc_q - ACT_START);
    y          = vc_q - VBLANK_END;
    chk_bit    = (|(x & X_MASK)) ^ (|(y & Y_MASK));
    ramp_sum   = BLANK_W + LW'(x >> 2);
    bar_lvl    = BLANK_W + LW'(bidx_q) * STEP_W;

    sample_d = BLANK_C;
    hsync_d  = 1'b0;
    active_d = 1'b0;
    if (sync_tim) begin
      sample_d = SYNC_C;
      hsync_d  = 1'b1;
    end else if (active_tim) begin
      active_d = 1'b1;
      case (pat_q)
        2'd0:    sample_d = FLAT_C;
        2'd1:    sample_d = (ramp_sum > WHITE_W) ? WHITE_C : DW'(ramp_sum);
        2'd2:    sample_d = (bidx_q == 3'd7) ? WHITE_C : DW'(bar_lvl);
        default: sample_d = chk_bit ? WHITE_C : BLANK_C;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hc_q        <= '0;
      vc_q        <= '0;
      pat_q       <= '0;
      bsub_q      <= '0;
      bidx_q      <= '0;
      sample_out  <= BLANK_C;
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      active_o    <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hc_q        <= '0;
      vc_q        <= '0;
      pat_q       <= '0;
      bsub_q      <= '0;
      bidx_q      <= '0;
      sample_out  <= BLANK_C;
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      active_o    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      pat_q       <= pat_d;
      bsub_q      <= bsub_d;
      bidx_q      <= bidx_d;
      sample_out  <= sample_d;
      hsync_o     <= hsync_d;
      vsync_o     <= broad_line;
      active_o    <= active_d;
      frame_start <= fs_d;
    end
  end

`ifdef PALGEN_INTERLACE_EN
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      field_q <= 1'b0;
      field_o <= 1'b0;
    end else if (!en) begin
      field_q <= 1'b0;
      field_o <= 1'b0;
    end else begin
      field_q <= field_d;
      field_o <= field_q;
    end
  end
`endif

endmodule
